// File: rtl/sine_freq_meter.sv
// sine_freq_meter: rising-midpoint-crossing frequency meter for 16-bit offset-binary samples.
// Over a gate of GATE_CYCLES clocks it reports whole periods (edge_cnt) and the clock span
// from the first to the last counted edge (cycle_cnt); f = edge_cnt * 100 MHz / cycle_cnt.
// Build option: define HYST_EN to use a +/-HYST band around the midpoint for crossing
// detection; without it the level is simply sample[15].
module sine_freq_meter #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter logic [15:0] HYST        = 16'd512,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      sample,
    input  logic             sample_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             no_signal
);

`ifdef HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // With a zero band the two thresholds meet at the midpoint and the level is sample[15].
    localparam logic [16:0] MID   = 17'd32768;
    localparam logic [16:0] BAND  = HYST_ON ? {1'b0, HYST} : 17'd0;
    localparam logic [16:0] LO_TH = MID - BAND;
    localparam logic [16:0] HI_TH = MID + BAND;

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_DONE
    } state_t;

    logic [16:0]      samp_x;
    logic             lvl_known_q, lvl_known_d;
    logic             lvl_q, lvl_d;
    logic             edge_q, edge_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] periods_q, periods_d;
    logic [CNT_W-1:0] last_t_q, last_t_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             no_signal_q, no_signal_d;

    assign samp_x = {1'b0, sample};

    // Level tracker: qualifying samples set LOW/HIGH, in-band samples hold; LOW->HIGH is an edge.
    always_comb begin
        lvl_known_d = lvl_known_q;
        lvl_d       = lvl_q;
        edge_d      = 1'b0;
        if (sample_valid) begin
            if (samp_x < LO_TH) begin
                lvl_known_d = 1'b1;
                lvl_d       = 1'b0;
            end else if (samp_x >= HI_TH) begin
                lvl_known_d = 1'b1;
                lvl_d       = 1'b1;
                edge_d      = lvl_known_q && !lvl_q;
            end
        end
    end

    // Edge detector registers; the edge event appears one cycle after its sample.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            lvl_known_q <= 1'b0;
            lvl_q       <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            lvl_known_q <= lvl_known_d;
            lvl_q       <= lvl_d;
            edge_q      <= edge_d;
        end
    end

    // Measurement FSM next state, counters and results; results load on the way into DONE.
    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        timer_d     = timer_q;
        periods_d   = periods_q;
        last_t_d    = last_t_q;
        edge_cnt_d  = edge_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        no_signal_d = no_signal_q;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ARM;
                    gate_d    = '0;
                    timer_d   = '0;
                    periods_d = '0;
                    last_t_d  = '0;
                end
            end
            S_ARM: begin
                busy   = 1'b1;
                gate_d = gate_q + 1'b1;
                if (edge_q) begin
                    timer_d = '0;
                    state_d = S_MEAS;
                end
                if (gate_q == GATE_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_MEAS: begin
                busy    = 1'b1;
                gate_d  = gate_q + 1'b1;
                timer_d = timer_q + 1'b1;
                if (edge_q) begin
                    periods_d = periods_q + 1'b1;
                    last_t_d  = timer_q + 1'b1;
                end
                if (gate_q == GATE_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Loading on the transition makes results valid in the done cycle and counts an
        // edge coinciding with gate expiry.
        if (state_q != S_DONE && state_d == S_DONE) begin
            no_signal_d = (periods_d == '0);
            edge_cnt_d  = (periods_d == '0) ? '0 : periods_d;
            cycle_cnt_d = (periods_d == '0) ? '0 : last_t_d;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gate_q      <= '0;
            timer_q     <= '0;
            periods_q   <= '0;
            last_t_q    <= '0;
            edge_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            no_signal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            timer_q     <= timer_d;
            periods_q   <= periods_d;
            last_t_q    <= last_t_d;
            edge_cnt_q  <= edge_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign edge_cnt  = edge_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: sine stimulus with a scoreboard of expected results per run.
module tb_sine_freq_meter;

    localparam int unsigned GATE   = 6000;
    localparam int unsigned PERIOD = 1000;
    localparam int unsigned CW     = 32;

    logic          clk_100M = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   sample = 16'h8000;
    logic          sample_valid = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] cycle_cnt;
    logic          no_signal;

    int unsigned g = 0;
    int          mode = 0;
    int          compared = 0;
    int          mismatched = 0;

    typedef struct {
        string       tag;
        int unsigned edges;
        int unsigned cycles;
        bit          nosig;
        int          kind;
    } exp_t;

    exp_t sb[$];

    sine_freq_meter #(
        .GATE_CYCLES(GATE),
        .HYST(16'd512),
        .CNT_W(CW)
    ) dut (
        .clk_100M(clk_100M),
        .rst_n(rst_n),
        .start(start),
        .sample(sample),
        .sample_valid(sample_valid),
        .busy(busy),
        .done(done),
        .edge_cnt(edge_cnt),
        .cycle_cnt(cycle_cnt),
        .no_signal(no_signal)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0 clean sine, 1 constant midpoint, 2 sine with +/-100 square dither, 3 clean sine
    function automatic logic [15:0] wave(input int unsigned gi, input int m);
        int  v;
        real ph;
        if (m == 1) return 16'h8000;
        ph = 6.283185307179586 * real'(gi % PERIOD) / real'(PERIOD);
        v  = 32768 + $rtoi(8000.0 * $sin(ph));
        if (m == 2) v = v + (((gi % 2) == 0) ? 100 : -100);
        return 16'(v);
    endfunction

    // Rising crossings fall at cycle 500 + k*PERIOD after start; events follow one cycle later.
    function automatic int unsigned exp_periods();
        int unsigned n = 0;
        for (int unsigned k = 0; 501 + k * PERIOD <= GATE; k++) n++;
        return (n == 0) ? 0 : n - 1;
    endfunction

    // Sample/valid driver, one new sample per cycle set up on the falling edge.
    initial begin
        forever begin
            @(negedge clk_100M);
            g            = g + 1;
            sample       = wave(g, mode);
            sample_valid = (mode == 3) ? ((g % 4) == 0) : 1'b1;
        end
    end

    task automatic compare_result();
        exp_t e;
        logic [63:0] diff;
        if (sb.size() == 0) begin
            check_val("unexpected_done", 1, 0);
            return;
        end
        e = sb.pop_front();
        check_val({e.tag, "_no_signal"}, no_signal, e.nosig);
        case (e.kind)
            0: begin
                check_val({e.tag, "_edge_cnt"}, edge_cnt, e.edges);
                check_val({e.tag, "_cycle_cnt"}, cycle_cnt, e.cycles);
            end
            1: begin
`ifdef HYST_EN
                check_val({e.tag, "_edge_cnt"}, edge_cnt, e.edges);
                check_val({e.tag, "_cycle_cnt"}, cycle_cnt, e.cycles);
`else
                check_val({e.tag, "_edge_cnt_gt"}, edge_cnt > e.edges, 1);
`endif
            end
            default: begin
                check_val({e.tag, "_edge_cnt"}, edge_cnt, e.edges);
                check_val({e.tag, "_cycle_mod4"}, cycle_cnt % 4, 0);
                diff = (cycle_cnt > edge_cnt * PERIOD) ? cycle_cnt - edge_cnt * PERIOD
                                                       : edge_cnt * PERIOD - cycle_cnt;
                check_val({e.tag, "_cycle_within4"}, diff <= 4, 1);
            end
        endcase
    endtask

    // One measurement: settle the waveform, start at phase 500, watch done over a bounded window.
    task automatic run_meas(input string tag, input int m, input int kind,
                            input bit second_start, input int unsigned abort_at,
                            input bit nosig);
        int unsigned n_done = 0;
        int unsigned done_c = 0;
        exp_t        e;
        mode = m;
        repeat (PERIOD) @(negedge clk_100M);
        do begin
            @(negedge clk_100M);
            #1;
        end while ((g % PERIOD) != PERIOD / 2);
        if (abort_at == 0) begin
            e.tag    = tag;
            e.nosig  = nosig;
            e.edges  = nosig ? 0 : exp_periods();
            e.cycles = e.edges * PERIOD;
            e.kind   = kind;
            sb.push_back(e);
        end
        start = 1'b1;
        for (int unsigned c = 1; c <= GATE + 50; c++) begin
            @(negedge clk_100M);
            #1;
            if (c == 1) begin
                start = 1'b0;
                check_val({tag, "_busy_c1"}, busy, 1);
            end
            if (second_start && c == 10) start = 1'b1;
            if (second_start && c == 11) start = 1'b0;
            if (abort_at != 0 && c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val({tag, "_rst_busy"}, busy, 0);
                check_val({tag, "_rst_done"}, done, 0);
                check_val({tag, "_rst_edge_cnt"}, edge_cnt, 0);
                check_val({tag, "_rst_cycle_cnt"}, cycle_cnt, 0);
                check_val({tag, "_rst_no_signal"}, no_signal, 0);
            end
            if (abort_at != 0 && c == abort_at + 3) rst_n = 1'b1;
            if (done === 1'b1) begin
                n_done++;
                done_c = c;
                check_val({tag, "_busy_at_done"}, busy, 0);
                compare_result();
            end
        end
        if (abort_at != 0) begin
            check_val({tag, "_no_done"}, n_done, 0);
        end else begin
            check_val({tag, "_done_count"}, n_done, 1);
            check_val({tag, "_done_cycle"}, done_c, GATE + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100M);
        #1;
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_edge_cnt", edge_cnt, 0);
        check_val("reset_cycle_cnt", cycle_cnt, 0);
        check_val("reset_no_signal", no_signal, 0);
        rst_n = 1'b1;

        run_meas("clean", 0, 0, 1'b1, 0, 1'b0);
        run_meas("abort", 0, 0, 1'b0, 3000, 1'b0);
        run_meas("post_rst", 0, 0, 1'b0, 0, 1'b0);
        run_meas("const", 1, 0, 1'b0, 0, 1'b1);
        run_meas("dither", 2, 1, 1'b0, 0, 1'b0);
        run_meas("valid4", 3, 2, 1'b0, 0, 1'b0);

        check_val("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
